sdram_ram_arbiter: RTL

Two-requester arbiter that shares the single native RAM request port of the SDRAM core (wr/rd/len/addr/data, accept/ack) between two masters. Examples are an AXI front-end and a DMA/video fetch engine. Grants whole bursts with round-robin fairness. Routes in-order acks and read data back to the issuing requester through a tag FIFO. Sits between the requesters and sdram_axi_core's inport.

---
 rtl/sdram_ram_arbiter_if.sv | 23 ++
 rtl/sdram_ram_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sdram_ram_arbiter_if.sv
// Native SDRAM RAM request port bundle (wr/rd/len/addr/data, accept/ack).
// master drives the request; slave answers with accept/ack/error/read data.
interface sdram_ram_arbiter_if;
  logic [3:0]  wr;
  logic        rd;
  logic [7:0]  len;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        accept;
  logic        ack;
  logic        error;
  logic [31:0] read_data;

  modport master (
    output wr, rd, len, addr, write_data,
    input  accept, ack, error, read_data
  );

  modport slave (
    input  wr, rd, len, addr, write_data,
    output accept, ack, error, read_data
  );
endinterface

// File: rtl/sdram_ram_arbiter.sv
// Two-requester burst arbiter for the SDRAM core RAM port, with an ack-routing tag FIFO.
// Optional macro SDRAM_ARB_FIXED_PRIO_EN: port 0 always wins contention instead of round-robin.
module sdram_ram_arbiter #(
  parameter int unsigned TAG_DEPTH   = 8,
  parameter int unsigned TAG_DEPTH_W = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sdram_ram_arbiter_if.slave  inport0,
  sdram_ram_arbiter_if.slave  inport1,
  sdram_ram_arbiter_if.master outport
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  localparam logic [TAG_DEPTH_W:0]   FullCount = (TAG_DEPTH_W + 1)'(TAG_DEPTH);
  localparam logic [TAG_DEPTH_W:0]   CountOne  = (TAG_DEPTH_W + 1)'(1);
  localparam logic [TAG_DEPTH_W-1:0] PtrOne    = TAG_DEPTH_W'(1);

  state_e                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_q, last_d;
  logic [7:0]             beats_q, beats_d;
  logic [TAG_DEPTH-1:0]   tags_q, tags_d;
  logic [TAG_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_DEPTH_W:0]   count_q, count_d;

  logic req0, req1, req_g, winner;
  logic full, empty, acc_ok, push, pop, head;

  always_comb begin
    req0  = (|inport0.wr) | inport0.rd;
    req1  = (|inport1.wr) | inport1.rd;
    req_g = grant_q ? req1 : req0;
    full  = (count_q == FullCount);
    empty = (count_q == '0);
    head  = tags_q[rd_ptr_q];

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    winner = ~req0;
`else
    winner = (req0 & req1) ? ~last_q : req1;
`endif

    // Full uses the registered count, so a same-cycle pop does not unblock accept.
    acc_ok = (state_q == StBurst) & outport.accept & ~full;
    push   = acc_ok & req_g;
    pop    = outport.ack & ~empty;

    outport.wr         = '0;
    outport.rd         = 1'b0;
    outport.len        = '0;
    outport.addr       = '0;
    outport.write_data = '0;
    if (state_q == StBurst && !full) begin
      outport.wr         = grant_q ? inport1.wr         : inport0.wr;
      outport.rd         = grant_q ? inport1.rd         : inport0.rd;
      outport.len        = grant_q ? inport1.len        : inport0.len;
      outport.addr       = grant_q ? inport1.addr       : inport0.addr;
      outport.write_data = grant_q ? inport1.write_data : inport0.write_data;
    end

    inport0.accept    = acc_ok & ~grant_q;
    inport1.accept    = acc_ok & grant_q;
    inport0.ack       = pop & ~head;
    inport1.ack       = pop & head;
    inport0.error     = pop & ~head & outport.error;
    inport1.error     = pop & head & outport.error;
    inport0.read_data = outport.read_data;
    inport1.read_data = outport.read_data;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    beats_d  = beats_q;
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          grant_d = winner;
          beats_d = winner ? inport1.len : inport0.len;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (push) begin
          beats_d = beats_q - 8'd1;
          if (beats_q == 8'd0) begin
            last_d  = grant_q;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (push) begin
      tags_d[wr_ptr_q] = grant_q;
      wr_ptr_d         = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      beats_q  <= '0;
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      beats_q  <= beats_d;
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
